// File: rtl/data_memory_responder_if.sv
// Load/store bus between the load_store_unit (master) and the data-memory responder (slave).
interface data_memory_responder_if;
  logic [15:0] mem_location;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] commit_data;
  logic [15:0] commit_location;
  logic        commit_valid;

  modport master (
    output mem_location, mem_valid, commit_data, commit_location, commit_valid,
    input  mem_data, mem_data_valid
  );

  modport slave (
    input  mem_location, mem_valid, commit_data, commit_location, commit_valid,
    output mem_data, mem_data_valid
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed 16-bit data memory with a fixed-latency load pipeline; committed stores
// are forwarded into every in-flight load so a load never returns stale data.
module data_memory_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int LOAD_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  data_memory_responder_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [15:0]             r_mem  [DEPTH];
  logic [LOAD_LATENCY-1:0] r_vld_p;
  logic [ADDR_BITS-1:0]    r_addr_p [LOAD_LATENCY];
  logic [15:0]             r_data_p [LOAD_LATENCY];

  logic [ADDR_BITS-1:0]    w_ld_addr;
  logic [ADDR_BITS-1:0]    w_st_addr;
  logic [ADDR_BITS-1:0]    w_nxt_addr [LOAD_LATENCY];
  logic [15:0]             w_nxt_data [LOAD_LATENCY];
  logic                    w_unused_bits;

  // Upper address bits are ignored: addresses alias modulo DEPTH.
  assign w_ld_addr     = bus.mem_location[ADDR_BITS-1:0];
  assign w_st_addr     = bus.commit_location[ADDR_BITS-1:0];
  assign w_unused_bits = ^{bus.mem_location[15:ADDR_BITS], bus.commit_location[15:ADDR_BITS]};

  function automatic logic [15:0] fwd_data(input logic [ADDR_BITS-1:0] addr,
                                           input logic [15:0]          old_data,
                                           input logic                 st_vld,
                                           input logic [ADDR_BITS-1:0] st_addr,
                                           input logic [15:0]          st_data);
    return (st_vld && (addr == st_addr)) ? st_data : old_data;
  endfunction

  // Write port: not reset, never gated by flush or reset.
  always_ff @(posedge clk) begin
    if (bus.commit_valid) r_mem[w_st_addr] <= bus.commit_data;
  end

  always_comb begin
    w_nxt_addr[0] = w_ld_addr;
    w_nxt_data[0] = fwd_data(w_ld_addr, r_mem[w_ld_addr],
                             bus.commit_valid, w_st_addr, bus.commit_data);
    for (int k = 1; k < LOAD_LATENCY; k++) begin
      w_nxt_addr[k] = r_addr_p[k-1];
      w_nxt_data[k] = fwd_data(r_addr_p[k-1], r_data_p[k-1],
                               bus.commit_valid, w_st_addr, bus.commit_data);
    end
  end

  // Stage boundary: address/data advance every edge, no reset on the datapath.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LOAD_LATENCY; k++) begin
      r_addr_p[k] <= w_nxt_addr[k];
      r_data_p[k] <= w_nxt_data[k];
    end
  end

  // Stage boundary: valid bits travel with the data and are the only reset/flush state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
    end else if (flush) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= bus.mem_valid;
      for (int k = 1; k < LOAD_LATENCY; k++) r_vld_p[k] <= r_vld_p[k-1];
    end
  end

  assign bus.mem_data_valid = r_vld_p[LOAD_LATENCY-1];
  assign bus.mem_data       = r_vld_p[LOAD_LATENCY-1] ? r_data_p[LOAD_LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed plus randomized bench for data_memory_responder with a queue-based reference model.
module tb_data_memory_responder;

  localparam int ADDR_BITS = 10;
  localparam int LAT       = 3;
  localparam int DEPTH     = 2 ** ADDR_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  data_memory_responder_if bus ();

  data_memory_responder #(.ADDR_BITS(ADDR_BITS), .LOAD_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int addr; } load_t;

  logic [15:0] mem_m [DEPTH];
  load_t       inflight [$];
  int          edge_cnt = 0;
  int          vectors  = 0;
  int          fails    = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, update the model with what was sampled, then check outputs.
  task automatic cycle(input logic mv, input logic [15:0] loc,
                       input logic cv, input logic [15:0] cloc, input logic [15:0] cdata,
                       input logic fl);
    logic        exp_vld;
    logic [15:0] exp_data;
    bus.mem_valid       = mv;
    bus.mem_location    = loc;
    bus.commit_valid    = cv;
    bus.commit_location = cloc;
    bus.commit_data     = cdata;
    flush               = fl;
    @(posedge clk);
    edge_cnt++;
    if (cv) mem_m[int'(cloc) % DEPTH] = cdata;
    if (!rst_n || fl) inflight.delete();
    else if (mv) inflight.push_back('{due: edge_cnt + LAT - 1, addr: int'(loc) % DEPTH});
    exp_vld  = 1'b0;
    exp_data = 16'h0000;
    while (inflight.size() > 0 && inflight[0].due <= edge_cnt) begin
      if (inflight[0].due == edge_cnt) begin
        exp_vld  = 1'b1;
        exp_data = mem_m[inflight[0].addr];
      end
      void'(inflight.pop_front());
    end
    #1;
    chk("mem_data_valid", {15'd0, bus.mem_data_valid}, {15'd0, exp_vld});
    chk("mem_data", bus.mem_data, exp_data);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic ld(input logic [15:0] a);
    cycle(1'b1, a, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic st(input logic [15:0] a, input logic [15:0] d);
    cycle(1'b0, 16'h0, 1'b1, a, d, 1'b0);
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_location = '0;
    bus.commit_valid = 1'b0; bus.commit_location = '0; bus.commit_data = '0;
    #2;
    chk("reset_valid", {15'd0, bus.mem_data_valid}, 16'd0);
    chk("reset_data", bus.mem_data, 16'h0000);
    idle();
    #2 rst_n = 1'b1;

    // Fill every word so all later loads have defined expectations.
    for (int i = 0; i < DEPTH; i++) st(16'(i), 16'($urandom));

    // Plan 1: store then load two cycles later.
    st(16'h0005, 16'hBEEF);
    idle();
    ld(16'h0005);
    repeat (4) idle();

    // Plan 2: back-to-back loads.
    st(16'h0001, 16'h0011); st(16'h0002, 16'h0022); st(16'h0003, 16'h0033);
    ld(16'h0001); ld(16'h0002); ld(16'h0003);
    repeat (4) idle();

    // Plan 3: same-cycle load/store, then store while load is in flight.
    st(16'h0010, 16'h1234);
    cycle(1'b1, 16'h0010, 1'b1, 16'h0010, 16'hABCD, 1'b0);
    repeat (3) idle();
    ld(16'h0010);
    st(16'h0010, 16'h5555);
    repeat (3) idle();

    // Plan 4: aliasing.
    st(16'h0400, 16'h7777);
    ld(16'h0000);
    repeat (3) idle();

    // Plan 5: flush with a fourth load and a store in the same cycle.
    ld(16'h0001); ld(16'h0002); ld(16'h0003);
    cycle(1'b1, 16'h0004, 1'b1, 16'h0020, 16'h9999, 1'b1);
    repeat (3) idle();
    ld(16'h0020);
    repeat (3) idle();

    // Plan 6: asynchronous reset with two loads in flight.
    ld(16'h0001); ld(16'h0005);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, bus.mem_data_valid}, 16'd0);
    chk("async_rst_data", bus.mem_data, 16'h0000);
    inflight.delete();
    idle(); idle();
    rst_n = 1'b1;
    ld(16'h0003);
    repeat (3) idle();

    // Randomized traffic concentrated on a few low addresses to exercise forwarding.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] la, sa;
      la = {6'($urandom), 10'($urandom_range(0, 7))};
      sa = {6'($urandom), 10'($urandom_range(0, 7))};
      cycle(1'($urandom_range(0, 3) != 0), la,
            1'($urandom_range(0, 2) == 0), sa, 16'($urandom),
            1'($urandom_range(0, 19) == 0));
    end
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
